// File: rtl/shared_mem_arbiter.sv
// Single-ported synchronous RAM shared by NUM_CORES cores through a round-robin
// arbiter, with an exclusive lock that lets one core hold the memory for read-modify-write.
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES-1:0]        lock,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        locked
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} lockState_e;

  lockState_e           state_q, state_d;
  logic [PTR_W-1:0]     rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [DATA_W-1:0]    mem [2**ADDR_W];

  logic                 winValid;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     scanPtr;
  int                   scanIdx;
  logic [ADDR_W-1:0]    winAddr;
  logic [DATA_W-1:0]    winData;
  logic                 winWe;
  logic                 winLock;

  function automatic logic [PTR_W-1:0] incWrap(input logic [PTR_W-1:0] idx);
    return (int'(idx) == NUM_CORES - 1) ? '0 : idx + 1'b1;
  endfunction

  // Winner selection: the owner alone while locked, otherwise the first request from rrPtr_q.
  always_comb begin
    winValid = 1'b0;
    win      = '0;
    scanIdx  = 0;
    scanPtr  = '0;
    if (state_q == ST_LOCKED) begin
      if (req[owner_q]) begin
        winValid = 1'b1;
        win      = owner_q;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        scanIdx = int'(rrPtr_q) + k;
        if (scanIdx >= NUM_CORES) scanIdx = scanIdx - NUM_CORES;
        scanPtr = PTR_W'(scanIdx);
        if (!winValid && req[scanPtr]) begin
          winValid = 1'b1;
          win      = scanPtr;
        end
      end
    end
    if (!rst_n) winValid = 1'b0;
  end

  assign winAddr = addr[win*ADDR_W +: ADDR_W];
  assign winData = wdata[win*DATA_W +: DATA_W];
  assign winWe   = we[win];
  assign winLock = lock[win];
  assign gnt     = winValid ? (NUM_CORES'(1) << win) : '0;

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    owner_d  = owner_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (winValid) begin
      if (!winWe) begin
        rvalid_d = NUM_CORES'(1) << win;
        rdata_d  = mem[winAddr];
      end
      if (state_q == ST_OPEN) begin
        rrPtr_d = incWrap(win);
        if (winLock) begin
          state_d = ST_LOCKED;
          owner_d = win;
        end
      end else if (!winLock) begin
        state_d = ST_OPEN;
        rrPtr_d = incWrap(owner_q);
      end
    end else if (state_q == ST_LOCKED && !req[owner_q] && !lock[owner_q]) begin
      // Owner walked away without a final access: release anyway.
      state_d = ST_OPEN;
      rrPtr_d = incWrap(owner_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_OPEN;
      rrPtr_q  <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (winValid && winWe) mem[winAddr] <= winData;
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed testbench for shared_mem_arbiter: sharing, round-robin order, lock,
// wrap-around, reset mid-lock and idle behaviour, with hand-computed expectations.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we, lock;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        locked;

  int compareCount = 0;
  int failCount    = 0;

  shared_mem_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .lock   (lock),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .locked (locked)
  );

  always #5 clk = ~clk;

  // Drive request/write/lock vectors for all cores at once.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
    req  = r;
    we   = w;
    lock = l;
  endtask

  // Set one core's address and write data in the packed buses.
  task automatic setCore(input int i, input logic [7:0] a, input logic [15:0] d);
    addr[i*8 +: 8]   = a;
    wdata[i*16 +: 16] = d;
  endtask

  // Advance to just after the next rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison; a mismatch is reported and counted, then the run continues.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] oneHot;

    // Reset with requests present: grant must be suppressed, state cleared.
    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    applyStimulus(4'b0101, 4'b0000, 4'b0000);
    #1;
    checkOutput("reset_gnt", gnt, 4'b0000);
    tick();
    checkOutput("reset_locked", locked, 1'b0);
    checkOutput("reset_rvalid", rvalid, 4'b0000);
    checkOutput("reset_rdata", rdata, 16'h0000);
    checkOutput("reset_ptr", dut.rrPtr_q, 2'd0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    // Core 2 writes BEEF to 0x10, then core 0 reads it back.
    setCore(2, 8'h10, 16'hBEEF);
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    #1;
    checkOutput("wr_gnt", gnt, 4'b0100);
    tick();
    checkOutput("wr_rvalid", rvalid, 4'b0000);
    setCore(0, 8'h10, 16'h0000);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    #1;
    checkOutput("rd_gnt", gnt, 4'b0001);
    tick();
    checkOutput("rd_rvalid", rvalid, 4'b0001);
    checkOutput("rd_rdata", rdata, 16'hBEEF);

    // Ten idle cycles: nothing granted, read data and pointer hold (ptr = 1 after core 0).
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      #1;
      checkOutput("idle_gnt", gnt, 4'b0000);
      tick();
      checkOutput("idle_rvalid", rvalid, 4'b0000);
    end
    checkOutput("idle_rdata", rdata, 16'hBEEF);
    checkOutput("idle_ptr", dut.rrPtr_q, 2'd1);

    // Preload 0x20+i with 0x1000+i, then reset (memory must survive).
    for (int i = 0; i < 4; i++) begin
      setCore(i, 8'(8'h20 + i), 16'(16'h1000 + i));
      oneHot = 4'(1 << i);
      applyStimulus(oneHot, oneHot, 4'b0000);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // All four cores read continuously: grants rotate 0,1,2,3,0.
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      oneHot = 4'(1 << (k % 4));
      #1;
      checkOutput("rr_gnt", gnt, oneHot);
      tick();
      checkOutput("rr_rvalid", rvalid, oneHot);
      checkOutput("rr_rdata", rdata, 16'(16'h1000 + (k % 4)));
    end

    // Lock: ptr = 1, core 1 reads with lock while cores 0 and 3 wait.
    setCore(0, 8'h20, 16'h0000);
    setCore(1, 8'h21, 16'hABCD);
    setCore(3, 8'h23, 16'h0000);
    applyStimulus(4'b1011, 4'b0000, 4'b0010);
    #1;
    checkOutput("lock_gnt1", gnt, 4'b0010);
    tick();
    checkOutput("lock_locked1", locked, 1'b1);
    checkOutput("lock_rvalid1", rvalid, 4'b0010);
    checkOutput("lock_rdata1", rdata, 16'h1001);
    #1;
    checkOutput("lock_gnt2", gnt, 4'b0010);
    tick();
    checkOutput("lock_locked2", locked, 1'b1);
    checkOutput("lock_rvalid2", rvalid, 4'b0010);
    applyStimulus(4'b1011, 4'b0010, 4'b0000);
    #1;
    checkOutput("lock_wb_gnt", gnt, 4'b0010);
    checkOutput("lock_wb_locked", locked, 1'b1);
    tick();
    checkOutput("unlock_locked", locked, 1'b0);
    checkOutput("unlock_rvalid", rvalid, 4'b0000);
    checkOutput("unlock_ptr", dut.rrPtr_q, 2'd2);
    applyStimulus(4'b1001, 4'b0000, 4'b0000);
    #1;
    checkOutput("post_gnt3", gnt, 4'b1000);
    tick();
    checkOutput("post_rdata3", rdata, 16'h1003);
    setCore(0, 8'h21, 16'h0000);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    #1;
    checkOutput("post_gnt0", gnt, 4'b0001);
    tick();
    checkOutput("post_rdata0", rdata, 16'hABCD);

    // Wrap-around: only core 3, then only core 0.
    setCore(3, 8'h20, 16'h0000);
    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    #1;
    checkOutput("wrap_gnt3", gnt, 4'b1000);
    tick();
    checkOutput("wrap_ptr", dut.rrPtr_q, 2'd0);
    checkOutput("wrap_rdata3", rdata, 16'h1000);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    #1;
    checkOutput("wrap_gnt0", gnt, 4'b0001);
    tick();
    checkOutput("wrap_rvalid0", rvalid, 4'b0001);

    // Reset in the middle of a lock held by core 2.
    setCore(2, 8'h22, 16'h0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0100);
    #1;
    checkOutput("rlock_gnt", gnt, 4'b0100);
    tick();
    checkOutput("rlock_locked", locked, 1'b1);
    checkOutput("rlock_rdata", rdata, 16'h1002);
    applyStimulus(4'b1111, 4'b0000, 4'b0100);
    #1;
    checkOutput("rlock_owner_gnt", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    checkOutput("rlock_rst_gnt", gnt, 4'b0000);
    tick();
    checkOutput("rlock_rst_locked", locked, 1'b0);
    checkOutput("rlock_rst_rvalid", rvalid, 4'b0000);
    checkOutput("rlock_rst_rdata", rdata, 16'h0000);
    checkOutput("rlock_rst_ptr", dut.rrPtr_q, 2'd0);
    rst_n = 1'b1;
    applyStimulus(4'b1110, 4'b0000, 4'b0000);
    #1;
    checkOutput("rlock_after_gnt", gnt, 4'b0010);
    tick();
    checkOutput("rlock_after_rvalid", rvalid, 4'b0010);
    checkOutput("rlock_after_rdata", rdata, 16'hABCD);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised shared data memory with an N-core round-robin arbiter. It replaces the fixed four-port memory hookup in the multi-core multiplier top: any number of cores share one single-ported synchronous RAM through a request/grant handshake. Beyond plain sharing, it adds fair round-robin ordering, per-core read-valid signalling, and an exclusive lock so one core can hold the memory across a read-modify-write sequence.

## Interface
- NUM_CORES, 4, number of requesting cores (≥2)
- ADDR_W, 8, word address width; memory depth = 2**ADDR_W
- DATA_W, 16, word width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req  in  NUM_CORES  per-core access request; held until granted
- we  in  NUM_CORES  per-core write enable; valid with req
- lock  in  NUM_CORES  per-core lock request; valid with req
- addr  in  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CORES*DATA_W  packed write data; core i at [i*DATA_W +: DATA_W]
- gnt  out  NUM_CORES  one-hot (or zero) combinational grant for the current cycle
- rvalid  out  NUM_CORES  registered; bit i high for one cycle when rdata holds core i's read
- rdata  out  DATA_W  registered read data, shared by all cores
- locked  out  1  registered; high while a core owns the lock

## Operation
- State: rr_ptr (log2 NUM_CORES bits, priority start), owner (core index), locked flag, RAM array.
- Arbitration (combinational): if locked, gnt = bit owner when req[owner] is high, else gnt = 0. If not locked, scan req starting at rr_ptr, wrapping modulo NUM_CORES; first set bit is the winner. No request gives gnt = 0.
- Access at the edge closing a granted cycle, for winner w:
  - we[w]=1: RAM[addr_w] <= wdata_w. rvalid stays 0.
  - we[w]=0: rdata <= RAM[addr_w]; rvalid <= one-hot w.
- Pointer: rr_ptr <= (w+1) mod NUM_CORES after each grant while unlocked. It is unchanged during locked grants and on idle cycles.
- Lock entry: a granted access with lock[w]=1 sets locked=1 and owner=w on that edge. Later accesses by w keep the lock while lock[w]=1.
- Lock release: a granted access by owner with lock[w]=0 is performed, then clears locked and sets rr_ptr <= (owner+1) mod NUM_CORES. The owner dropping req and lock together, with no access, also releases on that edge.
- While locked, all non-owner requests are stalled. Their gnt is 0 and they must hold req, addr, wdata and we.
- Memory contents are not cleared by reset.

## Timing
- Grant latency: 0 cycles. gnt is valid in the same cycle as req, and the core may drop req on the next edge.
- Write is visible to any read granted in the following cycle or later.
- Read latency: 1 cycle. rdata and rvalid are valid in the cycle after the grant, and rvalid is a single-cycle pulse.
- Back-to-back grants to different cores are allowed every cycle, giving a throughput of 1 access/cycle.
- Reset values on the edge with rst_n=0: rr_ptr=0, locked=0, owner=0, rvalid=0, rdata=0.
- gnt is forced to 0 while rst_n=0.
- If reset arrives mid-lock, the lock is dropped and the core-0-first order is restored.
- All cores requesting continuously are served in the order ptr, ptr+1, …, wrapping. Worst-case wait while unlocked is NUM_CORES-1 cycles.

## Test plan
- Reset, then core 2 writes 16'hBEEF to addr 8'h10; one cycle later core 0 reads 8'h10. Required: gnt=4'b0100, then 4'b0001; the next cycle gives rvalid=4'b0001 and rdata=16'hBEEF.
- All 4 cores request reads continuously from reset. Required: gnt sequence 0001, 0010, 0100, 1000, 0001; each rvalid pulse follows its grant by 1 cycle.
- Core 1 reads with lock=1 while cores 0 and 3 request. Core 1 then writes back with lock=0. Required: locked=1 between the two accesses and cores 0 and 3 get no grant. After release, the next grant is to core 3 (ptr=2 scan), then core 0.
- Only core 3 requests, then only core 0. Required: wrap-around gnt=1000 then 0001, with rr_ptr=0 after the core 3 grant.
- rst_n=0 for one cycle while core 2 holds the lock with other requests pending. Required: locked=0, rvalid=0, rdata=0; the next grant goes to the lowest requesting index starting from 0.
- No requests for 10 cycles. Required: gnt=0, rvalid=0, rdata and rr_ptr unchanged.
